// File: rtl/dtw_score_reader_if.sv
// Host-side bundle for the DTW score reader: pass control, cost stream and
// result handshake. Optional threshold signals exist only when
// DTW_THRESH_EN is defined.
interface dtw_score_reader_if #(
    parameter int unsigned width = 18,
    parameter int unsigned CNT_W = 16
);
    logic               start;
    logic [CNT_W-1:0]   len;
    logic [width-1:0]   cost_in;
    logic               cost_valid;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic [width-1:0]   res_score;
    logic [CNT_W-1:0]   res_pos;
`ifdef DTW_THRESH_EN
    logic [width-1:0]   thresh;
    logic               res_hit;
`endif

    // Host / control side
    modport master (
        output start, len, cost_in, cost_valid, res_ready,
`ifdef DTW_THRESH_EN
        output thresh,
        input  res_hit,
`endif
        input  busy, res_valid, res_score, res_pos
    );

    // Score reader side
    modport slave (
        input  start, len, cost_in, cost_valid, res_ready,
`ifdef DTW_THRESH_EN
        input  thresh,
        output res_hit,
`endif
        output busy, res_valid, res_score, res_pos
    );
endinterface

// File: rtl/dtw_score_reader.sv
// Reader end of the DTW systolic PE chain. Tracks the minimum bottom-row
// cost and the column where it first occurs, then presents the result on a
// valid/ready handshake until accepted.
// Optional feature macro: DTW_THRESH_EN (adds thresh input and res_hit output).
module dtw_score_reader #(
    parameter int unsigned width = 18,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    dtw_score_reader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               busy;
    logic               res_valid;
    logic [width-1:0]   res_score;
    logic [CNT_W-1:0]   res_pos;
    logic [width-1:0]   best;
    logic [CNT_W-1:0]   best_pos;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_q;

    logic               take;
    logic [width-1:0]   nxt_best;
    logic [CNT_W-1:0]   nxt_pos;
    logic               last;

`ifdef DTW_THRESH_EN
    logic               res_hit;
`endif

    // Candidate minimum including the current sample; strict compare keeps earliest tie
    always_comb begin
        take     = bus.cost_in < best;
        nxt_best = take ? bus.cost_in : best;
        nxt_pos  = take ? cnt : best_pos;
        last     = (cnt == (len_q - CNT_W'(1)));
    end

    // Pass control FSM with registered result and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_score <= '0;
            res_pos   <= '0;
            best      <= '1;
            best_pos  <= '0;
            cnt       <= '0;
            len_q     <= '0;
`ifdef DTW_THRESH_EN
            res_hit   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy <= 1'b1;
                        if (bus.len != '0) begin
                            len_q    <= bus.len;
                            best     <= '1;
                            best_pos <= '0;
                            cnt      <= '0;
                            state    <= RUN;
                        end else begin
                            // Empty pass reports the "no sample" sentinel
                            res_score <= '1;
                            res_pos   <= '0;
                            res_valid <= 1'b1;
`ifdef DTW_THRESH_EN
                            res_hit   <= ({width{1'b1}} <= bus.thresh);
`endif
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (bus.cost_valid) begin
                        best     <= nxt_best;
                        best_pos <= nxt_pos;
                        cnt      <= cnt + CNT_W'(1);
                        if (last) begin
                            res_score <= nxt_best;
                            res_pos   <= nxt_pos;
                            res_valid <= 1'b1;
`ifdef DTW_THRESH_EN
                            res_hit   <= (nxt_best <= bus.thresh);
`endif
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.res_valid = res_valid;
    assign bus.res_score = res_score;
    assign bus.res_pos   = res_pos;
`ifdef DTW_THRESH_EN
    assign bus.res_hit   = res_hit;
`endif
endmodule

// File: tb/tb_dtw_score_reader.sv
// Bench for dtw_score_reader: directed passes push expected results into a
// queue; a negedge monitor compares whatever the DUT presents.
module tb_dtw_score_reader;
    localparam int unsigned W  = 18;
    localparam int unsigned CW = 16;
    localparam logic [W-1:0] ALL1 = 18'h3FFFF;
    localparam logic [W-1:0] TH   = 18'd10;

    typedef struct {
        logic [W-1:0]  score;
        logic [CW-1:0] pos;
        logic          hit;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    dtw_score_reader_if #(.width(W), .CNT_W(CW)) bus ();

    dtw_score_reader #(.width(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] s, input logic [CW-1:0] p);
        exp_t e;
        e.score = s;
        e.pos   = p;
        e.hit   = (s <= TH);
        q.push_back(e);
    endtask

    task automatic do_start(input logic [CW-1:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] c);
        bus.cost_in    = c;
        bus.cost_valid = 1'b1;
        step();
        bus.cost_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.busy === 1'b1 && k < 50) begin
            step();
            k++;
        end
        chk(name, 32'(bus.busy), 32'd0);
    endtask

    // Scoreboard monitor: compare presented result, retire on handshake
    always @(negedge clk) begin
        if (!rst && bus.res_valid === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: score 0x%0h pos %0d with empty queue",
                         bus.res_score, bus.res_pos);
            end else begin
                chk("res_score", 32'(bus.res_score), 32'(q[0].score));
                chk("res_pos", 32'(bus.res_pos), 32'(q[0].pos));
`ifdef DTW_THRESH_EN
                chk("res_hit", 32'(bus.res_hit), 32'(q[0].hit));
`endif
                if (bus.res_ready === 1'b1) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.cost_in    = '0;
        bus.cost_valid = 1'b0;
        bus.res_ready  = 1'b1;
`ifdef DTW_THRESH_EN
        bus.thresh     = TH;
`endif
        idle(3);
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_score", 32'(bus.res_score), 32'd0);
        chk("rst_pos", 32'(bus.res_pos), 32'd0);
`ifdef DTW_THRESH_EN
        chk("rst_hit", 32'(bus.res_hit), 32'd0);
`endif

        // Basic min with earliest tie
        push_exp(18'd12, 16'd1);
        do_start(16'd5);
        chk("basic_busy_run", 32'(bus.busy), 32'd1);
        send(18'd40); send(18'd12); send(18'd30); send(18'd12);
        chk("basic_valid_early", 32'(bus.res_valid), 32'd0);
        send(18'd50);
        chk("basic_valid_lat", 32'(bus.res_valid), 32'd1);
        chk("basic_busy_done", 32'(bus.busy), 32'd1);
        step();
        chk("basic_busy_after", 32'(bus.busy), 32'd0);
        chk("basic_valid_after", 32'(bus.res_valid), 32'd0);

        // Bubbles and backpressure
        bus.res_ready = 1'b0;
        push_exp(18'd7, 16'd1);
        do_start(16'd3);
        send(18'd9); idle(4);
        send(18'd7); idle(2);
        send(18'd8);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_held", 32'(bus.res_valid), 32'd1);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        chk("bp_idle_after", 32'(bus.busy), 32'd0);
        chk("bp_valid_after", 32'(bus.res_valid), 32'd0);

        // len == 0
        push_exp(ALL1, 16'd0);
        do_start(16'd0);
        chk("len0_valid", 32'(bus.res_valid), 32'd1);
        wait_idle("len0_idle");

        // len == 1, maximum and zero cost
        push_exp(ALL1, 16'd0);
        do_start(16'd1);
        send(ALL1);
        chk("len1max_valid", 32'(bus.res_valid), 32'd1);
        wait_idle("len1max_idle");
        push_exp(18'd0, 16'd0);
        do_start(16'd1);
        send(18'd0);
        wait_idle("len1zero_idle");

        // start ignored in RUN and alongside the accepting handshake
        push_exp(18'd3, 16'd2);
        do_start(16'd4);
        send(18'd7);
        bus.start      = 1'b1;
        bus.len        = 16'd2;
        bus.cost_in    = 18'd9;
        bus.cost_valid = 1'b1;
        step();
        bus.start      = 1'b0;
        bus.cost_valid = 1'b0;
        send(18'd3);
        chk("ign_valid_3", 32'(bus.res_valid), 32'd0);
        send(18'd5);
        chk("ign_valid_4", 32'(bus.res_valid), 32'd1);
        bus.start = 1'b1;
        bus.len   = 16'd1;
        step();
        bus.start = 1'b0;
        chk("ign_busy_hs", 32'(bus.busy), 32'd0);
        idle(2);
        chk("ign_busy_later", 32'(bus.busy), 32'd0);
        chk("ign_valid_later", 32'(bus.res_valid), 32'd0);

        // Reset mid-pass
        do_start(16'd6);
        send(18'd4); send(18'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_score", 32'(bus.res_score), 32'd0);
        chk("mid_rst_pos", 32'(bus.res_pos), 32'd0);
        push_exp(18'd3, 16'd1);
        do_start(16'd2);
        send(18'd5); send(18'd3);
        wait_idle("fresh_idle");

`ifdef DTW_THRESH_EN
        // Threshold hit at equality and miss just above
        push_exp(18'd10, 16'd1);
        do_start(16'd2);
        send(18'd20); send(18'd10);
        chk("hit_eq", 32'(bus.res_hit), 32'd1);
        wait_idle("hit_eq_idle");
        push_exp(18'd11, 16'd1);
        do_start(16'd2);
        send(18'd20); send(18'd11);
        chk("hit_above", 32'(bus.res_hit), 32'd0);
        wait_idle("hit_above_idle");
`endif

        idle(2);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dtw_score_reader.md
Name: dtw_score_reader

Overview:
Reader end of the DTW systolic PE chain. Consumes the per-cycle cost stream from the last PE (bottom row of the DTW matrix) and tracks the minimum cost and the column index where it occurs. This gives a subsequence-DTW best score and end position. The result is presented on a valid/ready handshake to the host/control logic and held until accepted.

Parameters:
width, 18, bit width of cost samples and score; matches PE datapath width
CNT_W, 16, bit width of the sample counter, length and position

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a read pass (honoured only in IDLE)
len  input  CNT_W  number of cost samples in the pass; latched on accepted start
cost_in  input  width  unsigned cost from last PE (DTWc)
cost_valid  input  1  cost_in is a valid column sample this cycle
busy  output  1  high in RUN and DONE
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_score  output  width  minimum cost of the pass
res_pos  output  CNT_W  0-based index of the sample that gave res_score

Behaviour:
- Single clock domain. Reset is synchronous and active-high. rst has priority over all other inputs.
- Reset values:
  - state=IDLE, busy=0, res_valid=0
  - res_score=0, res_pos=0
  - internal best=all-ones, cnt=0, len_q=0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and len!=0: latch len_q=len, best=all-ones, best_pos=0, cnt=0; go to RUN.
  - start=1 and len==0: go straight to DONE with res_score=all-ones and res_pos=0.
  - cost_valid is ignored.
- RUN:
  - On each cycle with cost_valid=1: if cost_in < best (unsigned, strict), set best=cost_in and best_pos=cnt. Then cnt=cnt+1.
  - Ties keep the earliest index.
  - Cycles with cost_valid=0 do not advance; bubbles are allowed without limit.
  - Final sample: when cost_valid=1 and cnt==len_q-1, the final sample is included in the minimum. At that same edge, res_score and res_pos load the updated min and position, and state goes to DONE.
  - res_valid=1 from the cycle after the edge at which the final sample is sampled (1-cycle latency).
  - start is ignored.
- DONE:
  - res_valid=1; res_score and res_pos are held stable while res_ready=0.
  - res_valid & res_ready at an edge: go to IDLE and res_valid=0. res_score and res_pos retain their values.
  - start in the same cycle as the accepting handshake is ignored. A new pass needs start while in IDLE.
  - cost_valid is ignored.
- Width rules:
  - cnt and len_q are CNT_W bits; len up to 2^CNT_W-1 is supported. cnt never wraps because the pass ends at len_q-1.
  - Comparison is purely unsigned; no saturation is applied to cost_in.
- Reset mid-operation (RUN or DONE): abandons the pass and restores all reset values. A pending result is discarded.
- busy = (state != IDLE), driven from a register or decoded directly from the state register (no combinational path from inputs).

Optional Feature:
DTW_THRESH_EN. When defined:
- Adds input thresh (width) and output res_hit (1).
- res_hit is registered alongside res_score: res_hit = (final min <= thresh), with thresh sampled at the final-sample edge.
- res_hit resets to 0 and is held with the result.
- For a len==0 pass, res_hit = (all-ones <= thresh).

When not defined, the thresh and res_hit ports do not exist, and behaviour is otherwise identical.

Test Plan:
- Basic min: rst, then start with len=5; costs 40,12,30,12,50 back-to-back. Required: res_valid one cycle after the 5th sample, res_score=12, res_pos=1 (earliest tie wins), busy=1 until handshake.
- Bubbles and backpressure: len=3; costs 9, gap of 4 idle cycles, 7, gap of 2, 8; res_ready held low for 10 cycles. Required: res_score=7, res_pos=1, both stable and res_valid=1 throughout; IDLE the cycle after res_ready=1.
- Boundaries:
  - len=0: res_valid next cycle with res_score=0x3FFFF and res_pos=0.
  - len=1 with cost=0x3FFFF: res_score=0x3FFFF, res_pos=0.
  - len=1 with cost=0: res_score=0, res_pos=0.
- Ignored inputs: start pulsed during RUN with len=2 (in a len=4 pass), and start asserted together with the accepting handshake. Required: the pass still ends after 4 samples; no new pass starts; busy=0 after handshake.
- Reset mid-pass: after 2 of 6 samples, assert rst for 1 cycle. Required: res_valid=0, busy=0, res_score=0, res_pos=0. A fresh len=2 pass with costs 5,3 then yields res_score=3, res_pos=1.
- DTW_THRESH_EN: thresh=10. Costs 20,10 give res_hit=1. Costs 20,11 give res_hit=0. res_hit=0 after rst.
